// File: rtl/pulse_width_monitor.sv
// Synchronizes a single-bit level, counts its rising edges and measures the high
// time of each pulse; finished measurements queue in a small FIFO behind a valid/ready port.
module pulse_width_monitor #(
  parameter int WIDTH_W     = 16,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_W-1:0] out_width,
  output logic [CNT_W-1:0]   rise_count,
  output logic               overflow,
  output logic               dbg_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_e;

  // Handshake: an entry transfers on a rising clk edge where out_valid and
  // out_ready are both 1; out_valid never depends on out_ready, and the head
  // entry holds still while out_valid=1 and out_ready=0.

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q;
  logic                   s;
  logic                   rise;
  logic                   fall;

  state_e                 state_q;
  logic [WIDTH_W-1:0]     width_q;
  logic [CNT_W-1:0]       rise_count_q;
  logic                   overflow_q;

  logic [WIDTH_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
  logic                   empty;
  logic                   full;
  logic                   push_req;
  logic                   pop;
  logic                   push_ok;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;
  assign fall = ~s & p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      p_q    <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      width_q      <= '0;
      rise_count_q <= '0;
    end else begin
      if (rise) rise_count_q <= rise_count_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (rise) begin
            width_q <= {{(WIDTH_W-1){1'b0}}, 1'b1};
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (s) begin
            if (width_q != {WIDTH_W{1'b1}}) width_q <= width_q + 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The fall is pushed in the same cycle it is decoded so the entry is
  // visible SYNC_STAGES edges after the input first samples low.
  assign push_req = (state_q == HIGH) & fall;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop      = ~empty & out_ready;
  assign push_ok  = push_req & (~full | pop);
  assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= width_q;
      if (push_req & ~push_ok) overflow_q <= 1'b1;
    end
  end

  assign out_valid   = ~empty;
  assign out_width   = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign rise_count  = rise_count_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Bench for pulse_width_monitor: a 16-bit and a 4-bit instance share one stimulus
// stream and are compared every cycle against a run-length reference model.
module tb_pulse_width_monitor;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int MAX16 = 65535;
  localparam int MAX4  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_s;
  logic        rdy;

  logic        v16, ovf16, st16;
  logic [15:0] w16;
  logic [7:0]  rc16;
  logic        v4, ovf4, st4;
  logic [3:0]  w4;
  logic [7:0]  rc4;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit          lvl[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp4_q[$];
  int          run16, run4;
  logic [7:0]  m_rise;
  logic        m_ovf, m_ovf4;
  logic        w_zero;

  pulse_width_monitor #(.WIDTH_W(16), .CNT_W(8), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .in(in_s), .out_valid(v16), .out_ready(rdy),
    .out_width(w16), .rise_count(rc16), .overflow(ovf16), .dbg_state_o(st16)
  );

  pulse_width_monitor #(.WIDTH_W(4), .CNT_W(8), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) u_sat (
    .clk(clk), .rst(rst), .in(in_s), .out_valid(v4), .out_ready(rdy),
    .out_width(w4), .rise_count(rc4), .overflow(ovf4), .dbg_state_o(st4)
  );

  always #5 clk = ~clk;

  // The synchronized level seen at an edge is the input sampled SYNC edges
  // earlier (zero before reset release); a finished run of ones is a measurement.
  always @(posedge clk) begin
    bit s, p;
    if (rst) begin
      lvl.delete();
      for (int i = 0; i <= SYNC; i++) lvl.push_back(1'b0);
      exp_q.delete();
      exp4_q.delete();
      run16 = 0; run4 = 0;
      m_rise = '0; m_ovf = 1'b0; m_ovf4 = 1'b0;
      w_zero = 1'b1;
    end else begin
      s = lvl[lvl.size()-SYNC];
      p = lvl[lvl.size()-SYNC-1];
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (rdy && exp4_q.size() != 0) void'(exp4_q.pop_front());
      if (s && !p) m_rise = m_rise + 8'd1;
      if (!s && run16 > 0) begin
        w_zero = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(16'(run16)); else m_ovf = 1'b1;
        if (exp4_q.size() < DEPTH) exp4_q.push_back(16'(run4)); else m_ovf4 = 1'b1;
      end
      run16 = s ? ((run16 < MAX16) ? run16 + 1 : run16) : 0;
      run4  = s ? ((run4 < MAX4) ? run4 + 1 : run4) : 0;
      lvl.push_back(in_s);
      if (lvl.size() > 8) void'(lvl.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid16", {31'd0, v16}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("width16", {16'd0, w16}, {16'd0, exp_q[0]});
    else if (w_zero) chk("width16_rst", {16'd0, w16}, 32'd0);
    chk("rise16", {24'd0, rc16}, {24'd0, m_rise});
    chk("ovf16", {31'd0, ovf16}, {31'd0, m_ovf});
    chk("valid4", {31'd0, v4}, {31'd0, exp4_q.size() != 0});
    if (exp4_q.size() != 0) chk("width4", {28'd0, w4}, {16'd0, exp4_q[0]});
    else if (w_zero) chk("width4_rst", {28'd0, w4}, 32'd0);
    chk("rise4", {24'd0, rc4}, {24'd0, m_rise});
    chk("ovf4", {31'd0, ovf4}, {31'd0, m_ovf4});
  endtask

  task automatic cycle(input logic i, input logic r, input logic rs);
    in_s = i; rdy = r; rst = rs;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse(input int hi, input int lo, input logic r);
    for (int k = 0; k < hi; k++) cycle(1'b1, r, 1'b0);
    for (int k = 0; k < lo; k++) cycle(1'b0, r, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_s = 1'b1; rdy = 1'b0;
    @(negedge clk);

    // reset with input high, then a long idle low level
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1);
    chk("rst_width", {16'd0, w16}, 32'd0);
    for (int k = 0; k < 500; k++) cycle(1'b0, 1'b0, 1'b0);
    chk("idle_rise", {24'd0, rc16}, 32'd0);

    // single 5-cycle pulse, consumer always ready
    pulse(5, 6, 1'b1);
    chk("single_rise", {24'd0, rc16}, 32'd1);

    // back-pressure: five pulses into a four-entry FIFO
    cycle(1'b0, 1'b0, 1'b1);
    for (int w = 1; w <= 5; w++) pulse(w, 2, 1'b0);
    pulse(0, 3, 1'b0);
    chk("bp_ovf", {31'd0, ovf16}, 32'd1);
    pulse(0, 6, 1'b1);
    chk("bp_rise", {24'd0, rc16}, 32'd5);

    // full FIFO with a pop exactly in the push cycle of a 6-cycle pulse
    cycle(1'b0, 1'b0, 1'b1);
    for (int w = 2; w <= 5; w++) pulse(w, 4, 1'b0);
    pulse(6, 2, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    pulse(0, 3, 1'b0);
    chk("full_pop_ovf", {31'd0, ovf16}, 32'd0);
    pulse(0, 8, 1'b1);

    // saturation of the 4-bit instance
    pulse(20, 5, 1'b1);

    // back-to-back minimal pulses
    pulse(1, 1, 1'b1);
    pulse(1, 1, 1'b1);
    pulse(1, 4, 1'b1);

    // randomized levels and consumer readiness
    cycle(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      int len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) cycle(k[0], 1'($urandom_range(0, 1)), 1'b0);
    end
    pulse(0, 8, 1'b1);

    // reset during cycle 3 of a pulse, level held high for 500 cycles
    pulse(2, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("mid_rst_valid", {31'd0, v16}, 32'd0);
    pulse(500, 4, 1'b0);
    chk("long_valid", {31'd0, v16}, 32'd1);
    chk("long_rise", {24'd0, rc16}, 32'd1);
    chk("long_sat", {28'd0, w4}, 32'd15);
    pulse(0, 4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
